// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    // Compare width used by masked_eq; MAX_LEN must not exceed this.
    localparam int unsigned CMP_W = 64;

    localparam int unsigned DEF_LEN_C = 3;
    localparam logic [CMP_W-1:0] DEF_PATTERN_C = CMP_W'(3'b101);

    // Width of a field able to hold 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // True when the low len bits of a and b are equal.
    function automatic logic masked_eq(input logic [CMP_W-1:0] a,
                                       input logic [CMP_W-1:0] b,
                                       input int unsigned      len);
        logic [CMP_W-1:0] mask;
        mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
        return ((a ^ b) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX_C = '1;

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != MAX_C)) begin
            count <= count + CNT_W'(1);
            if (count == (MAX_C - CNT_W'(1))) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with Mealy match, registered
// match and saturating hit counter; supports overlapping and restart modes.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         CNT_W       = 8,
    parameter int unsigned         DEF_LEN     = DEF_LEN_C,
    parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        x_valid,
    input  logic                        x,
    input  logic                        overlap,
    input  logic                        cfg_we,
    input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
    input  logic [MAX_LEN-1:0]          cfg_pattern,
    input  logic                        cnt_clr,
    output logic                        z,
    output logic                        z_reg,
    output logic [CNT_W-1:0]            hit_count,
    output logic                        hit_sat
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] window;
    logic               cfg_load;
    logic               accepted;
    logic               fill_ok;

    // An out-of-range length leaves the config alone and lets the bit through.
    assign cfg_load = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accepted = x_valid && !cfg_load;
    assign window   = {hist, x};
    assign fill_ok  = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);

    assign z = !rst && accepted && fill_ok &&
               masked_eq(CMP_W'(window), CMP_W'(pat_q), 32'(len_q));

    // Non-overlap restarts the fill count after a match; otherwise saturate.
    always_comb begin
        fill_nxt = fill;
        if (z && !overlap) begin
            fill_nxt = '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
            fill_nxt = fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            len_q <= LEN_W'(DEF_LEN);
            pat_q <= DEF_PATTERN;
            z_reg <= 1'b0;
        end else begin
            z_reg <= z;
            if (cfg_load) begin
                len_q <= cfg_len;
                pat_q <= cfg_pattern;
                hist  <= '0;
                fill  <= '0;
            end else if (accepted) begin
                hist <= window[MAX_LEN-2:0];
                fill <= fill_nxt;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hits (
        .clk   (clk),
        .rst   (rst),
        .inc   (z),
        .clr   (cnt_clr),
        .count (hit_count),
        .sat   (hit_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a bit-queue reference model.
module tb_seq_detector_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               x_valid = 1'b0;
    logic               x = 1'b0;
    logic               overlap = 1'b0;
    logic               cfg_we = 1'b0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic               cnt_clr = 1'b0;
    logic               z;
    logic               z_reg;
    logic [CNT_W-1:0]   hit_count;
    logic               hit_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN     (MAX_LEN),
        .CNT_W       (CNT_W),
        .DEF_LEN     (3),
        .DEF_PATTERN (8'b0000_0101)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_valid     (x_valid),
        .x           (x),
        .overlap     (overlap),
        .cfg_we      (cfg_we),
        .cfg_len     (cfg_len),
        .cfg_pattern (cfg_pattern),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .z_reg       (z_reg),
        .hit_count   (hit_count),
        .hit_sat     (hit_sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted bits since the last flush, plus bits since restart.
    bit          mq[$];
    int          m_since = 0;
    int          m_len   = 3;
    logic [7:0]  m_pat   = 8'b101;
    int          m_cnt   = 0;
    bit          m_sat   = 1'b0;
    bit          m_zreg  = 1'b0;

    function automatic bit cfg_valid();
        return cfg_we && (cfg_len >= 1) && (cfg_len <= MAX_LEN);
    endfunction

    function automatic bit exp_z();
        bit b;
        if (rst || !x_valid || cfg_valid()) return 1'b0;
        if (m_since + 1 < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (i == 0) b = x;
            else if (i > mq.size()) return 1'b0;
            else b = mq[mq.size() - i];
            if (b != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit ez;
        if (rst) begin
            mq.delete();
            m_since = 0; m_len = 3; m_pat = 8'b101;
            m_cnt = 0; m_sat = 1'b0; m_zreg = 1'b0;
        end else begin
            ez = exp_z();
            if (cfg_valid()) begin
                m_len = int'(cfg_len);
                m_pat = cfg_pattern;
                mq.delete();
                m_since = 0;
            end else if (x_valid) begin
                mq.push_back(x);
                if (mq.size() > MAX_LEN) void'(mq.pop_front());
                if (ez && !overlap) m_since = 0;
                else m_since++;
            end
            if (cnt_clr) begin
                m_cnt = 0; m_sat = 1'b0;
            end else if (ez && m_cnt < CNT_MAX) begin
                m_cnt++;
                if (m_cnt == CNT_MAX) m_sat = 1'b1;
            end
            m_zreg = ez;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("z", 32'(z), 32'(exp_z()));
        chk("z_reg", 32'(z_reg), 32'(m_zreg));
        chk("hit_count", 32'(hit_count), 32'(m_cnt));
        chk("hit_sat", 32'(hit_sat), 32'(m_sat));
    end

    task automatic drive(input logic v, input logic xb, input logic ov, input logic we,
                         input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] pat,
                         input logic clr, output logic zs);
        x_valid = v; x = xb; overlap = ov; cfg_we = we;
        cfg_len = len; cfg_pattern = pat; cnt_clr = clr;
        #3;
        zs = z;
        @(posedge clk);
        #1;
        x_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic cfg(input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] pat);
        logic zs;
        drive(1'b0, 1'b0, 1'b0, 1'b1, len, pat, 1'b0, zs);
    endtask

    task automatic clr();
        logic zs;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, zs);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends n bits MSB-first; hits[i] records z on bit i+1.
    task automatic stream(input logic [15:0] bits, input int n, input logic ov,
                          input logic gaps, output logic [15:0] hits);
        logic zs;
        hits = '0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bits[n-1-i], ov, 1'b0, '0, '0, 1'b0, zs);
            hits[i] = zs;
            if (gaps) begin
                drive(1'b0, 1'b0, ov, 1'b0, '0, '0, 1'b0, zs);
                drive(1'b0, 1'b1, ov, 1'b0, '0, '0, 1'b0, zs);
            end
        end
    endtask

    initial begin
        logic [15:0] h;
        logic        zs;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_count", 32'(hit_count), 32'd0);
        chk("reset_sat", 32'(hit_sat), 32'd0);
        chk("reset_zreg", 32'(z_reg), 32'd0);

        stream(16'b1010_1101, 8, 1'b0, 1'b0, h);
        chk("nonovl_101_hits", 32'(h), 32'h0084);
        chk("nonovl_101_count", 32'(hit_count), 32'd2);
        chk("nonovl_101_zreg", 32'(z_reg), 32'd1);

        clr(); cfg(4'd3, 8'b101);
        stream(16'b1010_1101, 8, 1'b1, 1'b0, h);
        chk("ovl_101_hits", 32'(h), 32'h0094);
        chk("ovl_101_count", 32'(hit_count), 32'd3);
        chk("ovl_101_sat", 32'(hit_sat), 32'd1);

        clr(); cfg(4'd2, 8'b11);
        stream(16'b1111, 4, 1'b1, 1'b0, h);
        chk("ovl_11_hits", 32'(h), 32'h000E);
        clr(); cfg(4'd2, 8'b11);
        stream(16'b1111, 4, 1'b0, 1'b0, h);
        chk("nonovl_11_hits", 32'(h), 32'h000A);
        chk("nonovl_11_count", 32'(hit_count), 32'd2);

        clr(); cfg(4'd4, 8'b1101);
        stream(16'b110_1101, 7, 1'b1, 1'b1, h);
        chk("gaps_1101_hits", 32'(h), 32'h0048);
        chk("gaps_1101_count", 32'(hit_count), 32'd2);

        clr(); cfg(4'd1, 8'b1);
        stream(16'b111, 3, 1'b0, 1'b0, h);
        chk("sat_third_count", 32'(hit_count), 32'd3);
        chk("sat_third_flag", 32'(hit_sat), 32'd1);
        stream(16'b1, 1, 1'b0, 1'b0, h);
        chk("sat_hold_count", 32'(hit_count), 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, zs);
        chk("clr_hit_z", 32'(zs), 32'd1);
        chk("clr_hit_count", 32'(hit_count), 32'd0);
        chk("clr_hit_sat", 32'(hit_sat), 32'd0);

        pulse_rst();
        stream(16'b10, 2, 1'b0, 1'b0, h);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 8'hFF, 1'b0, zs);
        chk("bad_len_bit_kept", 32'(zs), 32'd1);

        stream(16'b10, 2, 1'b0, 1'b0, h);
        pulse_rst();
        stream(16'b1, 1, 1'b0, 1'b0, h);
        chk("rst_mid_no_z", 32'(h), 32'h0000);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 8'b11, 1'b0, zs);
        chk("cfg_bit_z", 32'(zs), 32'd0);
        stream(16'b11, 2, 1'b0, 1'b0, h);
        chk("cfg_bit_discarded", 32'(h), 32'h0002);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector: the successor to the fixed non-overlapping "101" Mealy detector. It matches a runtime-programmable pattern of 1..MAX_LEN bits on a qualified serial input stream. A mode input selects overlapping or non-overlapping detection. It produces a Mealy (same-cycle) match pulse, a registered copy of that pulse, and a saturating hit counter. It sits between a serial front end (bit plus valid) and status/interrupt logic.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, hit counter width
- DEF_LEN, 3, pattern length after reset
- DEF_PATTERN, 8'b0000_0101, pattern after reset, right-aligned
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- x_valid  in  1  x is an accepted stream bit this cycle
- x  in  1  serial data bit
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled per accepted bit
- cfg_we  in  1  load cfg_len/cfg_pattern and flush history
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit len-1 is first-received
- cnt_clr  in  1  synchronous clear of hit_count and hit_sat
- z  out  1  Mealy match: combinational, same cycle as the completing bit
- z_reg  out  1  z registered, one cycle later
- hit_count  out  CNT_W  saturating count of matches
- hit_sat  out  1  sticky, hit_count reached all-ones

## Operation
- State: hist (MAX_LEN-1 bits, shift-in LSB), fill (accepted bits since last flush/match, saturating at MAX_LEN), len_q, pat_q, hit_count, hit_sat, z_reg.
- Accepted bit: x_valid=1 and cfg_we=0.
- z = accepted & (fill ≥ len_q−1) & ({hist, x} low len_q bits == pat_q low len_q bits).
- On an accepted bit, shift x into hist.
- fill update on an accepted bit:
  - z=1 and overlap=0 → fill ← 0 (non-overlap restart).
  - Otherwise → fill ← min(fill+1, MAX_LEN).
- x_valid=0: no state change except z_reg←0; z=0.
- cfg_we=1:
  - If 1 ≤ cfg_len ≤ MAX_LEN: load len_q/pat_q, clear hist and fill; the x bit that cycle is discarded; z=0.
  - Otherwise: ignored entirely. The bit is still processed as normal if x_valid=1.
- len_q=1: every accepted bit equal to pat_q[0] matches.
- hit_count increments on z=1 and saturates at 2^CNT_W−1. hit_sat sets when the count reaches that value.
- cnt_clr wins over a simultaneous hit: count becomes 0, hit_sat becomes 0.
- overlap changes take effect on the next accepted bit. History is not flushed.

## Timing
- Reset values: hist=0, fill=0, len_q=DEF_LEN, pat_q=DEF_PATTERN, z_reg=0, hit_count=0, hit_sat=0. z=0 while rst=1.
- z latency: 0 cycles (combinational from x, x_valid, cfg_we).
- z_reg, hit_count, hit_sat: update on the clock edge that samples z=1, visible the next cycle.
- Back-to-back accepted bits every cycle are supported, with no bubbles.
- rst asserted mid-pattern: partial match lost and config returns to defaults. The first match after release needs a full len_q accepted bits.

## Structure
- Package seq_det_pkg holds:
  - default length/pattern constants;
  - a function computing the len-masked compare;
  - the width helper for the len field.
- One sub-module, sat_counter (CNT_W, inc, clr, count, sat), is reused for hit_count/hit_sat.
- The detector core (hist/fill/compare) lives in the top level.

## Test plan
- Defaults, overlap=0, stream 1 0 1 0 1 1 0 1 with x_valid=1 every cycle:
  - z high on bits 3 and 8 only;
  - hit_count=2;
  - z_reg follows z one cycle later.
- Same stream, overlap=1: z on bits 3, 5, 8; hit_count=3.
- cfg_len=2, pattern 2'b11, stream 1 1 1 1:
  - overlap=1 → hits on bits 2, 3, 4;
  - overlap=0 → hits on bits 2, 4.
- cfg_len=4, pattern 4'b1101, overlap=1, stream 1 1 0 1 1 0 1 with x_valid=0 gaps inserted between bits: hits on bits 4 and 7 only; gaps change nothing.
- CNT_W=2, five hits:
  - hit_count=3 and hit_sat=1 after the third hit;
  - cnt_clr coincident with a hit → 0/0.
- Edge cases:
  - cfg_len=0 with cfg_we → config unchanged;
  - rst pulse after bits "1 0" → following bit 1 gives no z;
  - cfg_we with x_valid=1 → z=0 and the bit is discarded.
